// File: rtl/st2110_rtp_packetizer.sv
// rtl/st2110_rtp_packetizer.sv - ST2110-20 RTP packetizer from RGB pixel beats to a byte stream
// Buffers up to PIXELS_PER_PKT pixels, then sends RTP header, single-SRD payload header and RGB bytes.
module st2110_rtp_packetizer #(
  parameter int unsigned PIXELS_PER_PKT = 8,
  parameter logic [6:0]  PAYLOAD_TYPE   = 7'd96,
  parameter logic [31:0] SSRC           = 32'h0000_2110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pixel_data_in,
  input  logic        pixel_valid_in,
  output logic        pixel_ready_out,
  input  logic        pixel_sof_in,
  input  logic        pixel_eol_in,
  input  logic        pixel_eof_in,
  input  logic [31:0] rtp_ts_in,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  output logic        tx_last_out,
  input  logic        tx_ready_in,
  output logic        drop_pulse_out
);

  localparam int CW = $clog2(PIXELS_PER_PKT + 1);
  localparam int AW = (PIXELS_PER_PKT > 1) ? $clog2(PIXELS_PER_PKT) : 1;
  localparam logic [CW-1:0] FULL = CW'(PIXELS_PER_PKT);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HDR, S_PAY} state_t;

  state_t state, next_state;

  logic [23:0]   buffer [PIXELS_PER_PKT];
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic [AW-1:0] wr_idx;
  logic [31:0]   seq;
  logic [31:0]   ts;
  logic [14:0]   row;
  logic [14:0]   offset;
  logic [14:0]   row_base;
  logic [14:0]   off_base;
  logic [14:0]   pkt_row;
  logic [14:0]   pkt_offset;
  logic          marker;
  logic [4:0]    hdr_idx;
  logic [AW-1:0] pix_idx;
  logic [1:0]    comp;
  logic          ready_q;
  logic          drop_q;
  logic          pix_beat;
  logic          tx_beat;
  logic          close;
  logic          last_pix;
  logic          last_byte;
  logic [15:0]   cnt16;
  logic [15:0]   srd_len;
  logic [7:0]    hdr_byte;
  logic [7:0]    pay_byte;
  logic [23:0]   pix_word;

  assign pixel_ready_out = ready_q;
  assign drop_pulse_out  = drop_q;

  assign pix_beat = pixel_valid_in & ready_q;
  assign tx_beat  = tx_valid_out & tx_ready_in;

  // A sof beat restarts the packet: it always lands in slot 0.
  assign wr_idx      = pixel_sof_in ? '0 : count[AW-1:0];
  assign count_after = pixel_sof_in ? CW'(1) : count + 1'b1;
  assign close       = pix_beat & (pixel_eol_in | pixel_eof_in | (count_after == FULL));
  assign row_base    = pixel_sof_in ? 15'd0 : row;
  assign off_base    = pixel_sof_in ? 15'd0 : offset;

  assign last_pix  = (CW'(pix_idx) == count - 1'b1);
  assign last_byte = last_pix & (comp == 2'd2);

  assign cnt16   = 16'(count);
  assign srd_len = cnt16 + (cnt16 << 1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    tx_valid_out = 1'b0;
    tx_data_out  = 8'd0;
    tx_last_out  = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (close)         next_state = S_HDR;
        else if (pix_beat) next_state = S_COLLECT;
      end
      S_HDR: begin
        tx_valid_out = 1'b1;
        tx_data_out  = hdr_byte;
        if (tx_ready_in && hdr_idx == 5'd19) next_state = S_PAY;
      end
      S_PAY: begin
        tx_valid_out = 1'b1;
        tx_data_out  = pay_byte;
        tx_last_out  = last_byte;
        if (tx_ready_in && last_byte) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    hdr_byte = 8'd0;
    case (hdr_idx)
      5'd0:  hdr_byte = 8'h80;
      5'd1:  hdr_byte = {marker, PAYLOAD_TYPE};
      5'd2:  hdr_byte = seq[15:8];
      5'd3:  hdr_byte = seq[7:0];
      5'd4:  hdr_byte = ts[31:24];
      5'd5:  hdr_byte = ts[23:16];
      5'd6:  hdr_byte = ts[15:8];
      5'd7:  hdr_byte = ts[7:0];
      5'd8:  hdr_byte = SSRC[31:24];
      5'd9:  hdr_byte = SSRC[23:16];
      5'd10: hdr_byte = SSRC[15:8];
      5'd11: hdr_byte = SSRC[7:0];
      5'd12: hdr_byte = seq[31:24];
      5'd13: hdr_byte = seq[23:16];
      5'd14: hdr_byte = srd_len[15:8];
      5'd15: hdr_byte = srd_len[7:0];
      5'd16: hdr_byte = {1'b0, pkt_row[14:8]};
      5'd17: hdr_byte = pkt_row[7:0];
      5'd18: hdr_byte = {1'b0, pkt_offset[14:8]};
      5'd19: hdr_byte = pkt_offset[7:0];
      default: hdr_byte = 8'd0;
    endcase
  end

  always_comb begin
    pix_word = buffer[pix_idx];
    case (comp)
      2'd0:    pay_byte = pix_word[23:16];
      2'd1:    pay_byte = pix_word[15:8];
      default: pay_byte = pix_word[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (pix_beat) buffer[wr_idx] <= pixel_data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= '0;
      seq        <= 32'd0;
      ts         <= 32'd0;
      row        <= 15'd0;
      offset     <= 15'd0;
      pkt_row    <= 15'd0;
      pkt_offset <= 15'd0;
      marker     <= 1'b0;
      hdr_idx    <= 5'd0;
      pix_idx    <= '0;
      comp       <= 2'd0;
      ready_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      ready_q <= (next_state == S_IDLE) || (next_state == S_COLLECT);
      drop_q  <= pix_beat & pixel_sof_in & (count != '0);
      if (pix_beat) begin
        count <= count_after;
        if (pixel_sof_in) begin
          ts         <= rtp_ts_in;
          pkt_row    <= 15'd0;
          pkt_offset <= 15'd0;
        end else if (count == '0) begin
          pkt_row    <= row;
          pkt_offset <= offset;
        end
        if (close) begin
          hdr_idx <= 5'd0;
          pix_idx <= '0;
          comp    <= 2'd0;
          // eof wins over eol, which wins over a simultaneous size close.
          if (pixel_eof_in) begin
            marker <= 1'b1;
            row    <= 15'd0;
            offset <= 15'd0;
          end else if (pixel_eol_in) begin
            row    <= row_base + 15'd1;
            offset <= 15'd0;
          end else begin
            row    <= row_base;
            offset <= off_base + 15'(count_after);
          end
        end else if (pixel_sof_in) begin
          row    <= 15'd0;
          offset <= 15'd0;
        end
      end
      if (tx_beat) begin
        if (state == S_HDR) begin
          hdr_idx <= hdr_idx + 5'd1;
        end else if (last_byte) begin
          count  <= '0;
          marker <= 1'b0;
          seq    <= seq + 32'd1;
        end else if (comp == 2'd2) begin
          comp    <= 2'd0;
          pix_idx <= pix_idx + 1'b1;
        end else begin
          comp <= comp + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_st2110_rtp_packetizer.sv
// tb/tb_st2110_rtp_packetizer.sv - self-checking bench for st2110_rtp_packetizer
// Directed vector table plus randomized traffic against a queue-based packet model.
module tb_st2110_rtp_packetizer;

  localparam int PPP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] pixel_data_in;
  logic        pixel_valid_in;
  logic        pixel_ready_out;
  logic        pixel_sof_in;
  logic        pixel_eol_in;
  logic        pixel_eof_in;
  logic [31:0] rtp_ts_in;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_last_out;
  logic        tx_ready_in = 1'b0;
  logic        drop_pulse_out;

  st2110_rtp_packetizer #(
    .PIXELS_PER_PKT(PPP),
    .PAYLOAD_TYPE(7'd96),
    .SSRC(32'h0000_2110)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pixel_data_in(pixel_data_in),
    .pixel_valid_in(pixel_valid_in),
    .pixel_ready_out(pixel_ready_out),
    .pixel_sof_in(pixel_sof_in),
    .pixel_eol_in(pixel_eol_in),
    .pixel_eof_in(pixel_eof_in),
    .rtp_ts_in(rtp_ts_in),
    .tx_data_out(tx_data_out),
    .tx_valid_out(tx_valid_out),
    .tx_last_out(tx_last_out),
    .tx_ready_in(tx_ready_in),
    .drop_pulse_out(drop_pulse_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    bit          sof, eol, eof;
    logic [31:0] ts;
    bit          closes;
    logic [7:0]  b1;
    logic [15:0] len, row, off;
    logic [31:0] seq;
    logic [23:0] first_px;
  } vec_t;

  vec_t vecs[$];

  int n_pass = 0;
  int n_total = 0;

  logic [8:0]  exp_q[$];
  logic [23:0] m_buf[$];
  logic [31:0] m_seq = 0, m_ts = 0;
  logic [14:0] m_row = 0, m_off = 0, m_prow = 0, m_poff = 0;
  int          exp_drops = 0;

  logic [7:0] rx_log[$];
  int  pkt_pos = 0, cur_start = 0, last_start = 0, last_len = 0;
  int  drop_seen = 0;
  bit  prev_drop = 0, hold_v = 0, after_last = 0;
  logic [8:0] hold_d, e_byte;
  int  rdy_mode = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic void push_b(logic [7:0] b, bit last);
    exp_q.push_back({last, b});
  endfunction

  function automatic void model_emit(bit mk);
    int n = m_buf.size();
    logic [15:0] len = 16'(3 * n);
    logic [31:0] ssrc = 32'h0000_2110;
    push_b(8'h80, 0);
    push_b({mk, 7'd96}, 0);
    push_b(m_seq[15:8], 0);
    push_b(m_seq[7:0], 0);
    for (int i = 3; i >= 0; i--) push_b(m_ts[8*i +: 8], 0);
    for (int i = 3; i >= 0; i--) push_b(ssrc[8*i +: 8], 0);
    push_b(m_seq[31:24], 0);
    push_b(m_seq[23:16], 0);
    push_b(len[15:8], 0);
    push_b(len[7:0], 0);
    push_b({1'b0, m_prow[14:8]}, 0);
    push_b(m_prow[7:0], 0);
    push_b({1'b0, m_poff[14:8]}, 0);
    push_b(m_poff[7:0], 0);
    for (int k = 0; k < n; k++) begin
      push_b(m_buf[k][23:16], 0);
      push_b(m_buf[k][15:8], 0);
      push_b(m_buf[k][7:0], k == n - 1);
    end
    m_seq = m_seq + 32'd1;
  endfunction

  function automatic void model_beat(logic [23:0] d, bit sof, bit eol, bit eof, logic [31:0] ts);
    int n;
    if (sof) begin
      if (m_buf.size() != 0) exp_drops++;
      m_buf.delete();
      m_ts  = ts;
      m_row = 0;
      m_off = 0;
    end
    if (m_buf.size() == 0) begin
      m_prow = m_row;
      m_poff = m_off;
    end
    m_buf.push_back(d);
    n = m_buf.size();
    if (eol || eof || n == PPP) begin
      model_emit(eof);
      if (eof) begin
        m_row = 0;
        m_off = 0;
      end else if (eol) begin
        m_row = m_row + 15'd1;
        m_off = 0;
      end else begin
        m_off = m_off + 15'(n);
      end
      m_buf.delete();
    end
  endfunction

  function automatic void model_reset();
    m_buf.delete();
    exp_q.delete();
    m_seq = 0; m_ts = 0; m_row = 0; m_off = 0; m_prow = 0; m_poff = 0;
  endfunction

  function automatic void add(logic [23:0] d, bit sof, bit eol, bit eof, logic [31:0] ts, bit closes,
                              logic [7:0] b1, logic [15:0] len, logic [15:0] row, logic [15:0] off,
                              logic [31:0] seq, logic [23:0] first_px);
    vec_t v;
    v.d = d; v.sof = sof; v.eol = eol; v.eof = eof; v.ts = ts; v.closes = closes;
    v.b1 = b1; v.len = len; v.row = row; v.off = off; v.seq = seq; v.first_px = first_px;
    vecs.push_back(v);
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: tx_ready_in = 1'b1;
      1: tx_ready_in = ~tx_ready_in;
      default: tx_ready_in = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output monitor: handshake sampling, stability while stalled, scoreboard against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 0; pkt_pos = 0; after_last = 0; prev_drop = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 32'(tx_valid_out), 32'd1);
        chk("hold_data", 32'({tx_last_out, tx_data_out}), 32'(hold_d));
      end
      if (after_last) chk("idle_after_last", 32'(tx_valid_out), 32'd0);
      after_last = 0;
      if (tx_valid_out) chk("pix_ready_in_tx", 32'(pixel_ready_out), 32'd0);
      if (drop_pulse_out) begin
        drop_seen++;
        chk("drop_width", 32'(prev_drop), 32'd0);
      end
      prev_drop = drop_pulse_out;
      if (tx_valid_out && tx_ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'({tx_last_out, tx_data_out}), 32'h1ff);
        end else begin
          e_byte = exp_q.pop_front();
          chk("tx_byte", 32'({tx_last_out, tx_data_out}), 32'(e_byte));
        end
        rx_log.push_back(tx_data_out);
        if (pkt_pos == 0) cur_start = rx_log.size() - 1;
        pkt_pos++;
        if (tx_last_out) begin
          last_start = cur_start;
          last_len   = pkt_pos;
          pkt_pos    = 0;
          after_last = 1;
        end
        hold_v = 0;
      end else if (tx_valid_out) begin
        hold_v = 1;
        hold_d = {tx_last_out, tx_data_out};
      end else begin
        hold_v = 0;
      end
    end
  end

  task automatic send_pixel(input logic [23:0] d, input bit sof, input bit eol, input bit eof,
                            input logic [31:0] ts);
    bit ok = 0;
    int waited = 0;
    pixel_data_in = d; pixel_sof_in = sof; pixel_eol_in = eol; pixel_eof_in = eof;
    rtp_ts_in = ts; pixel_valid_in = 1'b1;
    while (!ok && waited < 400) begin
      @(negedge clk);
      if (pixel_ready_out) ok = 1;
      @(posedge clk);
      #1;
      waited++;
    end
    pixel_valid_in = 1'b0; pixel_sof_in = 1'b0; pixel_eol_in = 1'b0; pixel_eof_in = 1'b0;
    chk("pix_accept", 32'(ok), 32'd1);
    if (ok) model_beat(d, sof, eol, eof, ts);
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int s;
    bit sof, eol, eof;
    logic [7:0] t1_hdr [20];
    t1_hdr = '{8'h80, 8'h60, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00,
               8'h21, 8'h10, 8'h00, 8'h00, 8'h00, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};

    rst_n = 1'b0;
    pixel_data_in = 0; pixel_valid_in = 0; pixel_sof_in = 0; pixel_eol_in = 0;
    pixel_eof_in = 0; rtp_ts_in = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid_out), 32'd0);
    chk("rst_tx_last", 32'(tx_last_out), 32'd0);
    chk("rst_tx_data", 32'(tx_data_out), 32'd0);
    chk("rst_pix_ready", 32'(pixel_ready_out), 32'd0);
    chk("rst_drop", 32'(drop_pulse_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1/T3: 8 px with sof, ts 12345678, size close
    for (int k = 0; k < 8; k++)
      add(24'h010203 + 24'(k) * 24'h030303, k == 0, 0, 0, 32'h12345678, k == 7,
          8'h60, 16'h0018, 16'h0000, 16'h0000, 32'd0, 24'h010203);
    // T2: eol on px2, then a 2-px line starting at row 1
    for (int k = 0; k < 3; k++)
      add(24'hA00000 + 24'(k), 0, k == 2, 0, 0, k == 2, 8'h60, 16'h0009, 16'h0000, 16'h0008, 32'd1, 24'hA00000);
    for (int k = 0; k < 2; k++)
      add(24'hB00000 + 24'(k), 0, k == 1, 0, 0, k == 1, 8'h60, 16'h0006, 16'h0001, 16'h0000, 32'd2, 24'hB00000);
    // T4: eof+eol on px4
    for (int k = 0; k < 5; k++)
      add(24'hC00000 + 24'(k), 0, k == 4, k == 4, 0, k == 4, 8'hE0, 16'h000F, 16'h0002, 16'h0000, 32'd3, 24'hC00000);
    // T5: sof at count 3 discards the partial packet
    for (int k = 0; k < 3; k++)
      add(24'hD00000 + 24'(k), k == 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add(24'hE00000 + 24'(k), k == 0, 0, 0, 32'h0BADBEEF, k == 7,
          8'h60, 16'h0018, 16'h0000, 16'h0000, 32'd4, 24'hE00000);

    rdy_mode = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      send_pixel(v.d, v.sof, v.eol, v.eof, v.ts);
      if (v.closes) begin
        wait_drain();
        s = last_start;
        chk("pkt_b1", 32'(rx_log[s+1]), 32'(v.b1));
        chk("pkt_seq", {rx_log[s+12], rx_log[s+13], rx_log[s+2], rx_log[s+3]}, v.seq);
        chk("pkt_len", 32'({rx_log[s+14], rx_log[s+15]}), 32'(v.len));
        chk("pkt_row", 32'({rx_log[s+16], rx_log[s+17]}), 32'(v.row));
        chk("pkt_off", 32'({rx_log[s+18], rx_log[s+19]}), 32'(v.off));
        chk("pkt_first_px", 32'({rx_log[s+20], rx_log[s+21], rx_log[s+22]}), 32'(v.first_px));
        chk("pkt_bytes", 32'(last_len), 32'(20 + 3 * (v.len / 3)));
        if (i == 7) begin
          for (int k = 0; k < 20; k++) chk("t1_hdr", 32'(rx_log[s+k]), 32'(t1_hdr[k]));
          for (int k = 0; k < 8; k++)
            chk("t1_px", 32'({rx_log[s+20+3*k], rx_log[s+21+3*k], rx_log[s+22+3*k]}),
                32'(24'h010203 + 24'(k) * 24'h030303));
        end
      end
    end
    chk("t5_drops", 32'(drop_seen), 32'd1);

    // Randomized traffic with random downstream backpressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      eof = ($urandom_range(0, 24) == 0);
      eol = eof || ($urandom_range(0, 5) == 0);
      sof = ($urandom_range(0, 14) == 0);
      send_pixel(24'($urandom), sof, eol, eof, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    send_pixel(24'h123456, 0, 1, 0, 0);
    wait_drain();
    chk("rand_drops", 32'(drop_seen), 32'(exp_drops));

    // T6: reset while payload byte 5 is on the bus
    rdy_mode = 0;
    for (int k = 0; k < 8; k++) send_pixel(24'hF00000 + 24'(k), 0, 0, 0, 0);
    for (int w = 0; w < 200 && pkt_pos != 25; w++) begin
      @(posedge clk);
      #1;
    end
    chk("t6_reached_pay5", 32'(pkt_pos), 32'd25);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_valid_after_rst", 32'(tx_valid_out), 32'd0);
    chk("t6_pix_ready_rst", 32'(pixel_ready_out), 32'd0);
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pixel(24'h445566, 0, 1, 0, 0);
    wait_drain();
    s = last_start;
    chk("t6_seq_lo", 32'({rx_log[s+2], rx_log[s+3]}), 32'd0);
    chk("t6_seq_hi", 32'({rx_log[s+12], rx_log[s+13]}), 32'd0);
    chk("t6_row_off", 32'({rx_log[s+16], rx_log[s+17], rx_log[s+18], rx_log[s+19]}), 32'd0);
    chk("t6_len", 32'({rx_log[s+14], rx_log[s+15]}), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
